vga_sig_gen: RTL and testbench

- Downstream consumer of the frame buffer's read-only port B.
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Issues pixel read addresses for a 160x120 1-bit image and converts each returned bit into an 8-bit foreground or background colour.
- Drives the Basys3 VGA connector through a fixed-latency pipeline, so sync and colour stay aligned.

---
 rtl/vga_sig_gen_if.sv | 22 ++
 rtl/vga_sig_gen.sv | 120 ++++++++++++
 tb/tb_vga_sig_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vga_sig_gen_if.sv
// Frame-buffer read port and VGA connector signals of vga_sig_gen.
// master = the signal generator, slave = frame buffer / connector side.
interface vga_sig_gen_if;
  logic [15:0] CONFIG_COLOURS;
  logic        VGA_DATA;
  logic [14:0] VGA_ADDR;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [7:0]  VGA_COLOUR;
  logic        FRAME_IRQ;
  logic        FRAME_IRQ_ACK;

  modport master (
    input  CONFIG_COLOURS, VGA_DATA, FRAME_IRQ_ACK,
    output VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR, FRAME_IRQ
  );

  modport slave (
    output CONFIG_COLOURS, VGA_DATA, FRAME_IRQ_ACK,
    input  VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR, FRAME_IRQ
  );
endinterface

// File: rtl/vga_sig_gen.sv
// 640x480@60 VGA timing generator reading a 160x120 1-bit frame buffer through a 2-tick pipeline.
// Optional frame-end interrupt enabled by defining VGA_FRAME_IRQ_EN.
module vga_sig_gen #(
  parameter int PixDiv     = 4,
  parameter int HorVis     = 640,
  parameter int HorFP      = 16,
  parameter int HorSync    = 96,
  parameter int HorBP      = 48,
  parameter int VertVis    = 480,
  parameter int VertFP     = 10,
  parameter int VertSync   = 2,
  parameter int VertBP     = 33,
  parameter int ScaleShift = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  vga_sig_gen_if.master  vga
);

  localparam int HorTotal  = HorVis + HorFP + HorSync + HorBP;
  localparam int VertTotal = VertVis + VertFP + VertSync + VertBP;
  localparam int DivW      = (PixDiv > 1) ? $clog2(PixDiv) : 1;
  localparam int HW        = $clog2(HorTotal);
  localparam int VW        = $clog2(VertTotal);

  localparam logic [DivW-1:0] DivLast    = DivW'(PixDiv - 1);
  localparam logic [HW-1:0]   HorLast    = HW'(HorTotal - 1);
  localparam logic [HW-1:0]   HorVisEnd  = HW'(HorVis);
  localparam logic [HW-1:0]   HorSyncLo  = HW'(HorVis + HorFP);
  localparam logic [HW-1:0]   HorSyncHi  = HW'(HorVis + HorFP + HorSync - 1);
  localparam logic [VW-1:0]   VertLast   = VW'(VertTotal - 1);
  localparam logic [VW-1:0]   VertVisEnd = VW'(VertVis);
  localparam logic [VW-1:0]   VertSyncLo = VW'(VertVis + VertFP);
  localparam logic [VW-1:0]   VertSyncHi = VW'(VertVis + VertFP + VertSync - 1);

  logic [DivW-1:0] div_count;
  logic [HW-1:0]   h_count;
  logic [VW-1:0]   v_count;
  logic            tick;
  logic            vis;
  logic [15:0]     h_wide;
  logic [15:0]     v_wide;
  logic [14:0]     fb_addr;

  // Stage 1 (address + delayed syncs) and stage 2 (connector outputs)
  logic [14:0] addr_q;
  logic        hs_d, vs_d, vis_d;
  logic [7:0]  colour_q;
  logic        hs_q, vs_q;

  assign tick    = (div_count == DivLast);
  assign vis     = (h_count < HorVisEnd) && (v_count < VertVisEnd);
  assign h_wide  = 16'(h_count);
  assign v_wide  = 16'(v_count);
  assign fb_addr = {7'(v_wide >> ScaleShift), 8'(h_wide >> ScaleShift)};

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments let stage 2 consume stage 1's previous-tick values in the same edge.
    if (!RESET) begin
      div_count <= '0;
      h_count   <= '0;
      v_count   <= '0;
      addr_q    <= '0;
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      vis_d     <= 1'b0;
      colour_q  <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      div_count <= tick ? '0 : div_count + 1'b1;
      if (tick) begin
        if (h_count == HorLast) begin
          h_count <= '0;
          v_count <= (v_count == VertLast) ? '0 : v_count + 1'b1;
        end else begin
          h_count <= h_count + 1'b1;
        end

        addr_q <= vis ? fb_addr : '0;
        hs_d   <= ~((h_count >= HorSyncLo) && (h_count <= HorSyncHi));
        vs_d   <= ~((v_count >= VertSyncLo) && (v_count <= VertSyncHi));
        vis_d  <= vis;

        // VGA_DATA has settled for PixDiv-1 clocks since addr_q last changed
        colour_q <= vis_d ? (vga.VGA_DATA ? vga.CONFIG_COLOURS[15:8] : vga.CONFIG_COLOURS[7:0]) : '0;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
      end
    end
  end

  assign vga.VGA_ADDR   = addr_q;
  assign vga.VGA_HS     = hs_q;
  assign vga.VGA_VS     = vs_q;
  assign vga.VGA_COLOUR = colour_q;

`ifdef VGA_FRAME_IRQ_EN
  logic irq_q;

  // Setting on the last visible pixel takes priority over a coincident acknowledge
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      irq_q <= 1'b0;
    end else if (tick && (h_count == HorVisEnd - 1'b1) && (v_count == VertVisEnd - 1'b1)) begin
      irq_q <= 1'b1;
    end else if (vga.FRAME_IRQ_ACK) begin
      irq_q <= 1'b0;
    end
  end

  assign vga.FRAME_IRQ = irq_q;
`else
  logic unused_irq_ack;

  assign unused_irq_ack = vga.FRAME_IRQ_ACK;
  assign vga.FRAME_IRQ  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sig_gen.sv
// Scoreboard bench for vga_sig_gen on a shrunken raster; random image and colours, mid-frame reset, syncs and IRQ.
module tb_vga_sig_gen;

  localparam int PD  = 4;
  localparam int HV  = 40, HFP = 4, HSY = 8, HBP = 4;
  localparam int VV  = 24, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT  = HV + HFP + HSY + HBP;
  localparam int VT  = VV + VFP + VSY + VBP;
  localparam int FRAME_TICKS = HT * VT;
  localparam int LAST_VIS    = (VV - 1) * HT + (HV - 1);

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  colour;
    logic        hs;
    logic        vs;
  } exp_t;

  logic CLK;
  logic RESET;
  vga_sig_gen_if vif ();

  bit   img [0:32767];
  exp_t sb_q [$];
  int   tests = 0;
  int   fails = 0;

  vga_sig_gen #(
    .PixDiv(PD), .HorVis(HV), .HorFP(HFP), .HorSync(HSY), .HorBP(HBP),
    .VertVis(VV), .VertFP(VFP), .VertSync(VSY), .VertBP(VBP), .ScaleShift(2)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .vga   (vif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Frame buffer port B stand-in: one-clock read latency
  always @(posedge CLK) vif.VGA_DATA <= img[vif.VGA_ADDR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int px_h(input int t);
    return t % HT;
  endfunction

  function automatic int px_v(input int t);
    return (t / HT) % VT;
  endfunction

  function automatic logic [14:0] addr_of(input int t);
    int h = px_h(t);
    int v = px_v(t);
    if (h < HV && v < VV) return 15'((v / 4) * 256 + (h / 4));
    return 15'd0;
  endfunction

  // Expected outputs just after tick t: address of pixel t, colour/sync of pixel t-1
  function automatic exp_t model(input int t, input logic [15:0] cc);
    exp_t e;
    int   h, v;
    e.addr   = addr_of(t);
    e.colour = 8'h00;
    e.hs     = 1'b1;
    e.vs     = 1'b1;
    if (t > 0) begin
      h = px_h(t - 1);
      v = px_v(t - 1);
      if (h < HV && v < VV) e.colour = img[addr_of(t - 1)] ? cc[15:8] : cc[7:0];
      e.hs = !(h >= HV + HFP && h < HV + HFP + HSY);
      e.vs = !(v >= VV + VFP && v < VV + VFP + VSY);
    end
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_hs"},     32'(vif.VGA_HS),     32'd1);
    check({tag, "_vs"},     32'(vif.VGA_VS),     32'd1);
    check({tag, "_colour"}, 32'(vif.VGA_COLOUR), 32'd0);
    check({tag, "_addr"},   32'(vif.VGA_ADDR),   32'd0);
    check({tag, "_irq"},    32'(vif.FRAME_IRQ),  32'd0);
  endtask

  // One slot per pixel tick; each slot starts on the negedge after the previous tick
  task automatic run_slots(input int n, input bit with_acks);
    bit hold;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 7) == 0) vif.CONFIG_COLOURS = 16'($urandom);
      sb_q.push_back(model(t, vif.CONFIG_COLOURS));
      hold = with_acks && (t == LAST_VIS + FRAME_TICKS);
      vif.FRAME_IRQ_ACK = hold || (with_acks && (t == LAST_VIS + 25));
      @(negedge CLK);
      if (!hold) vif.FRAME_IRQ_ACK = 1'b0;
      repeat (3) @(negedge CLK);
      vif.FRAME_IRQ_ACK = 1'b0;
    end
  endtask

  // Monitor: tracks ticks independently, pops the scoreboard and measures sync timing
  initial begin : monitor
    int     cnt = 0;
    int     ntick = 0;
    longint clk_n = 0;
    longint hs_fall_t = 0, vs_fall_t = 0;
    bit     hs_fall_ok = 0, vs_fall_ok = 0;
    bit     prev_hs = 1, prev_vs = 1;
    bit     irq_exp = 0;
    bit     is_tick;
    exp_t   e;
    forever begin
      @(posedge CLK);
      clk_n++;
      if (!RESET) begin
        cnt = 0; ntick = 0; irq_exp = 0;
        hs_fall_ok = 0; vs_fall_ok = 0; prev_hs = 1; prev_vs = 1;
      end else begin
        is_tick = (cnt == PD - 1);
        cnt = is_tick ? 0 : cnt + 1;
`ifdef VGA_FRAME_IRQ_EN
        if (is_tick && (ntick % FRAME_TICKS) == LAST_VIS) irq_exp = 1;
        else if (vif.FRAME_IRQ_ACK) irq_exp = 0;
`endif
        if (is_tick) begin
          #1;
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("addr",   32'(vif.VGA_ADDR),   32'(e.addr));
            check("colour", 32'(vif.VGA_COLOUR), 32'(e.colour));
            check("hs",     32'(vif.VGA_HS),     32'(e.hs));
            check("vs",     32'(vif.VGA_VS),     32'(e.vs));
          end
          check("irq", 32'(vif.FRAME_IRQ), 32'(irq_exp));
          if (prev_hs && !vif.VGA_HS) begin
            if (hs_fall_ok) check("hs_period", 32'(clk_n - hs_fall_t), 32'(HT * PD));
            hs_fall_t = clk_n; hs_fall_ok = 1;
          end else if (!prev_hs && vif.VGA_HS && hs_fall_ok) begin
            check("hs_low_width", 32'(clk_n - hs_fall_t), 32'(HSY * PD));
          end
          if (prev_vs && !vif.VGA_VS) begin
            if (hs_fall_ok) check("vs_hs_align", 32'(clk_n - hs_fall_t), 32'((HT - HV - HFP) * PD));
            if (vs_fall_ok) check("vs_period", 32'(clk_n - vs_fall_t), 32'(FRAME_TICKS * PD));
            vs_fall_t = clk_n; vs_fall_ok = 1;
          end else if (!prev_vs && vif.VGA_VS && vs_fall_ok) begin
            check("vs_low_width", 32'(clk_n - vs_fall_t), 32'(VSY * HT * PD));
          end
          prev_hs = vif.VGA_HS;
          prev_vs = vif.VGA_VS;
          ntick++;
        end
      end
    end
  end

  initial begin : driver
    RESET = 1'b0;
    vif.CONFIG_COLOURS = 16'hE003;
    vif.FRAME_IRQ_ACK  = 1'b0;
    for (int i = 0; i < 32768; i++) img[i] = 1'($urandom);

    repeat (10) @(negedge CLK);
    check_reset_state("reset");
    RESET = 1'b1;

    // Abort part-way through a frame, around line 12
    run_slots(HT * 12 + 17, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_state("mid_reset");
    RESET = 1'b1;

    run_slots(3 * FRAME_TICKS, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
